// File: rtl/tl_sensor.sv
// ============================================================================
// Module   : tl_sensor
// Purpose  : Vehicle-loop conditioning for the two-street traffic light
//            controller. Each lane has a 2-flop synchronizer, a debouncer
//            and a presence FSM that stretches "traffic present" so the
//            controller never sees chatter on Ta/Tb.
// Options  : define TL_SENSOR_CNT_EN to add saturating per-lane vehicle
//            counters (cnt_clr, car_cnt_a, car_cnt_b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_sensor #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
`ifdef TL_SENSOR_CNT_EN
    ,
    parameter int CNT_W       = 4
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_a_raw,
    input  logic             sensor_b_raw,
    output logic             Ta,
    output logic             Tb
`ifdef TL_SENSOR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] car_cnt_a,
    output logic [CNT_W-1:0] car_cnt_b
`endif
);

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Bit 0 of the encoding is the presence flag, and ACTIVE<->HOLD differ
    // only in bit 1, so T taken straight from bit 0 is a clean flop output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        ACTIVE = 2'b11
    } lane_state_t;

    logic [1:0] raw_v;
    logic [1:0] t_v;

    assign raw_v = {sensor_b_raw, sensor_a_raw};
    assign Ta    = t_v[0];
    assign Tb    = t_v[1];

`ifdef TL_SENSOR_CNT_EN
    logic [2*CNT_W-1:0] cnt_flat;
    assign car_cnt_a = cnt_flat[CNT_W-1:0];
    assign car_cnt_b = cnt_flat[2*CNT_W-1:CNT_W];
`endif

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic        s1;
        logic        s2;
        logic        deb;
        logic [7:0]  dcnt;
        logic [7:0]  hcnt;
        logic [7:0]  hcnt_nxt;
        lane_state_t state;
        lane_state_t state_nxt;

        // Synchronize the raw sensor and accept a new level only after it
        // has persisted for DEB_CYCLES consecutive synchronized samples.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                deb  <= 1'b0;
                dcnt <= 8'd0;
            end else begin
                s1 <= raw_v[i];
                s2 <= s1;
                if (s2 == deb) begin
                    dcnt <= 8'd0;
                end else if (dcnt == DEB_LAST) begin
                    deb  <= s2;
                    dcnt <= 8'd0;
                end else begin
                    dcnt <= dcnt + 8'd1;
                end
            end
        end

        // Presence FSM state and hold counter registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= IDLE;
                hcnt  <= 8'd0;
            end else begin
                state <= state_nxt;
                hcnt  <= hcnt_nxt;
            end
        end

        // Next state: a debounced high always (re)enters ACTIVE; HOLD keeps
        // presence asserted for HOLD_CYCLES after the vehicle leaves.
        always_comb begin
            state_nxt = state;
            hcnt_nxt  = hcnt;
            case (state)
                IDLE: begin
                    if (deb) state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (!deb) begin
                        state_nxt = HOLD;
                        hcnt_nxt  = HOLD_LAST;
                    end
                end
                HOLD: begin
                    if (deb) begin
                        state_nxt = ACTIVE;
                    end else if (hcnt == 8'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        hcnt_nxt = hcnt - 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign t_v[i] = state[0];

`ifdef TL_SENSOR_CNT_EN
        logic [CNT_W-1:0] cnt;

        // Count new vehicles (IDLE->ACTIVE only), saturating; clear wins.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (cnt_clr) begin
                cnt <= '0;
            end else if ((state == IDLE) && deb && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign cnt_flat[i*CNT_W +: CNT_W] = cnt;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_tl_sensor.sv
// ============================================================================
// Module   : tb_tl_sensor
// Purpose  : Self-checking bench for tl_sensor. Directed steps from the test
//            plan followed by random sensor traffic, all compared every
//            cycle against a history-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_sensor;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [299:0] DMASK = (300'(1) << DEB) - 300'(1);
    localparam logic [299:0] HMASK = (300'(1) << (HOLD + 1)) - 300'(1);

    logic clk;
    logic reset_n;
    logic sa;
    logic sb;
    logic clr;
    logic Ta;
    logic Tb;
`ifdef TL_SENSOR_CNT_EN
    logic [CW-1:0] car_cnt_a;
    logic [CW-1:0] car_cnt_b;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: histories of synchronized samples and of the
    // debounced level; the decisions are window predicates over them.
    logic [299:0] s2w [2];
    logic [299:0] dw  [2];
    logic         m_s1  [2];
    logic         m_s2  [2];
    logic         m_deb [2];
    logic         m_t   [2];
    int           m_cnt [2];

    tl_sensor #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD)
`ifdef TL_SENSOR_CNT_EN
        ,
        .CNT_W       (CW)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sensor_a_raw (sa),
        .sensor_b_raw (sb),
        .Ta           (Ta),
        .Tb           (Tb)
`ifdef TL_SENSOR_CNT_EN
        ,
        .cnt_clr      (clr),
        .car_cnt_a    (car_cnt_a),
        .car_cnt_b    (car_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            s2w[i]   = '0;
            dw[i]    = '0;
            m_s1[i]  = 1'b0;
            m_s2[i]  = 1'b0;
            m_deb[i] = 1'b0;
            m_t[i]   = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare outputs 1 ns later.
    task automatic tick();
        logic [1:0] rv;
        logic       clr_s;
        logic       tn;
        @(posedge clk);
        rv    = {sb, sa};
        clr_s = clr;
        for (int i = 0; i < 2; i++) begin
            dw[i]  = {dw[i][298:0], m_deb[i]};
            s2w[i] = {s2w[i][298:0], m_s2[i]};
            if (((s2w[i] ^ {300{m_deb[i]}}) & DMASK) == DMASK) m_deb[i] = ~m_deb[i];
            tn = |(dw[i] & HMASK);
            if (clr_s) m_cnt[i] = 0;
            else if (!m_t[i] && tn && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            m_t[i]  = tn;
            m_s2[i] = m_s1[i];
            m_s1[i] = rv[i];
        end
        #1;
        chk("Ta", {7'd0, Ta}, {7'd0, m_t[0]});
        chk("Tb", {7'd0, Tb}, {7'd0, m_t[1]});
`ifdef TL_SENSOR_CNT_EN
        chk("car_cnt_a", 8'(car_cnt_a), 8'(m_cnt[0]));
        chk("car_cnt_b", 8'(car_cnt_b), 8'(m_cnt[1]));
`endif
    endtask

    task automatic cyc(input logic a, input logic b, input logic c);
        @(negedge clk);
        sa  = a;
        sb  = b;
        clr = c;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        sa      = 1'b0;
        sb      = 1'b0;
        clr     = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_Ta", {7'd0, Ta}, 8'd0);
        chk("reset_Tb", {7'd0, Tb}, 8'd0);
`ifdef TL_SENSOR_CNT_EN
        chk("reset_cnt_a", 8'(car_cnt_a), 8'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Rise on lane A: Ta low through edge 6, high after edge 7.
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (k == 6) chk("rise_e6_Ta", {7'd0, Ta}, 8'd0);
            if (k == 7) chk("rise_e7_Ta", {7'd0, Ta}, 8'd1);
            chk("rise_Tb", {7'd0, Tb}, 8'd0);
        end

        // Short pulse on lane B is rejected.
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1, (k <= 3), 1'b0);
            chk("short_Tb", {7'd0, Tb}, 8'd0);
        end

        // Fall on lane A: Ta high through edge 14, low after edge 15.
        for (int k = 1; k <= 18; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (k == 14) chk("fall_e14_Ta", {7'd0, Ta}, 8'd1);
            if (k == 15) chk("fall_e15_Ta", {7'd0, Ta}, 8'd0);
        end

        // Re-trigger during HOLD: Ta must never drop.
        for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            cyc((k < 9 || k > 14), 1'b0, 1'b0);
            chk("retrig_Ta", {7'd0, Ta}, 8'd1);
        end
`ifdef TL_SENSOR_CNT_EN
        chk("retrig_cnt_a", 8'(car_cnt_a), 8'd2);
`endif

        // Asynchronous reset while ACTIVE, asserted between edges.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        sa      = 1'b0;
        #1;
        chk("async_rst_Ta", {7'd0, Ta}, 8'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("post_rst_Ta", {7'd0, Ta}, 8'd0);
        end

`ifdef TL_SENSOR_CNT_EN
        // 17 full vehicles saturate the lane A counter at 15.
        cyc(1'b0, 1'b0, 1'b1);
        for (int v = 0; v < 17; v++) begin
            for (int k = 0; k < 8; k++)  cyc(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0);
        end
        chk("sat_cnt_a", 8'(car_cnt_a), 8'd15);
        // Clear coincides with the IDLE->ACTIVE edge (edge 7 after rise).
        for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("clr_win_Ta", {7'd0, Ta}, 8'd1);
        chk("clr_win_cnt_a", 8'(car_cnt_a), 8'd0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0);
`endif

        // Random traffic on both lanes.
        for (int k = 0; k < 1500; k++) begin
            logic na;
            logic nb;
            logic nc;
            na = ($urandom_range(0, 5) == 0) ? ~sa : sa;
            nb = ($urandom_range(0, 5) == 0) ? ~sb : sb;
`ifdef TL_SENSOR_CNT_EN
            nc = ($urandom_range(0, 49) == 0);
`else
            nc = 1'b0;
`endif
            cyc(na, nb, nc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tl_sensor.md
Name: tl_sensor

Overview:
- Upstream conditioning stage for the two-street traffic light controller.
- Converts raw, asynchronous, bouncy vehicle-loop sensors into the clean traffic-present inputs Ta/Tb that the controller consumes.
- Per lane: 2-flop synchronizer, debouncer, and presence FSM that holds "traffic present" for a minimum time after the vehicle leaves, so the controller never sees chatter.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized cycles a new level must persist before it is accepted (range 1..255).
- HOLD_CYCLES, 8, cycles T stays asserted after the debounced sensor falls (range 1..255).
- CNT_W, 4, width of the per-lane vehicle counters (optional feature only).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- sensor_a_raw  input  1  raw loop sensor, street A; asynchronous to clk.
- sensor_b_raw  input  1  raw loop sensor, street B; asynchronous to clk.
- Ta  output  1  registered traffic-present, street A; drives controller Ta.
- Tb  output  1  registered traffic-present, street B; drives controller Tb.
- cnt_clr  input  1  synchronous clear of both counters (TL_SENSOR_CNT_EN only).
- car_cnt_a  output  CNT_W  vehicles counted, street A (TL_SENSOR_CNT_EN only).
- car_cnt_b  output  CNT_W  vehicles counted, street B (TL_SENSOR_CNT_EN only).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time): all synchronizer flops, debounced levels, debounce and hold counters, and car counts go to 0. FSMs go to IDLE. Ta=Tb=0 immediately, with no clock needed.
- Lanes A and B are identical and fully independent. The rules below are per lane.
- Synchronizer:
  - s1 <= raw; s2 <= s1.
  - s2 reflects raw after 2 edges.
- Debouncer:
  - Holds accepted level deb and counter dcnt.
  - If s2==deb: dcnt <= 0.
  - If s2!=deb and dcnt==DEB_CYCLES-1: deb <= s2, dcnt <= 0.
  - Otherwise: dcnt <= dcnt+1.
  - Result: deb changes on the DEB_CYCLES-th consecutive edge with s2!=deb. Any shorter excursion is discarded.
- Presence FSM (Moore; T decoded from the state register, no combinational path from inputs):
  - IDLE (T=0): deb=1 -> ACTIVE.
  - ACTIVE (T=1): deb=0 -> HOLD, load hcnt=HOLD_CYCLES-1.
  - HOLD (T=1):
    - deb=1 -> ACTIVE (re-trigger).
    - Else if hcnt==0 -> IDLE.
    - Else hcnt <= hcnt-1.
  - deb=1 takes priority over hcnt expiry.
- Latency:
  - Rise: raw rising before edge 1 gives T=1 after edge DEB_CYCLES+3 (edge 7 at defaults).
  - Fall: raw falling before edge 1 gives T=0 after edge DEB_CYCLES+3+HOLD_CYCLES (edge 15 at defaults).
  - HOLD lasts exactly HOLD_CYCLES cycles.
- Raw toggling faster than DEB_CYCLES: deb and T unchanged.

Optional Feature:
- Macro: TL_SENSOR_CNT_EN.
- Defined:
  - cnt_clr, car_cnt_a and car_cnt_b exist.
  - Each count increments by 1 only on an IDLE->ACTIVE transition. HOLD->ACTIVE is the same vehicle and does not count.
  - Counts saturate at 2^CNT_W-1.
  - cnt_clr=1 sets both counts to 0 at the next edge. Clear wins over a same-cycle increment.
- Undefined: these ports and all counter logic are absent. Ta/Tb behaviour is identical in both builds.

Test Plan (defaults, 10 ns clock):
- Async reset mid-ACTIVE: drive reset_n=0 between edges -> Ta=0 within the same half-cycle without an edge; after release, Ta stays 0 until a new debounced rise.
- sensor_a_raw 0->1, held 20 cycles -> Ta=0 through edge 6, Ta=1 after edge 7; Tb stays 0 throughout.
- sensor_b_raw high for 3 cycles, then low -> Tb never asserts; debounced level for lane B stays 0.
- sensor_a_raw 1->0 from ACTIVE -> Ta stays 1 for 14 edges, Ta=0 after edge 15.
- Re-trigger during HOLD: raise sensor_a_raw so deb rises while in HOLD -> Ta never drops; the FSM returns to ACTIVE; with TL_SENSOR_CNT_EN, car_cnt_a does not increment.
- With TL_SENSOR_CNT_EN and CNT_W=4:
  - 17 separate vehicles (full rise/fall/HOLD expiry each) -> car_cnt_a=15, saturated.
  - Then cnt_clr=1 on the same cycle as an IDLE->ACTIVE transition -> car_cnt_a=0.
